// File: rtl/miner_pkg.sv
// Shared definitions for the nonce scheduler slice.
// Contents:
//   sched_state_t       - scheduler FSM state encoding
//   DEF_* localparams   - default parameter constants
//   RES_W               - width of one result FIFO entry {nonce, hash}
//   hash_meets_target() - leading-zero test on a 256-bit hash
//   sat_inc8()          - saturating 8-bit increment
package miner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_t;

    localparam int DEF_FLUSH_CYCLES = 64;
    localparam int DEF_ZERO_BITS    = 32;
    localparam int DEF_RES_DEPTH    = 4;
    localparam int RES_W            = 288;

    // True when the top zero_bits bits of the hash are all zero.
    function automatic logic hash_meets_target(input logic [255:0] hash, input int zero_bits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if ((i >= (256 - zero_bits)) && hash[i]) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // Increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding qualified results.
// Read data is first-word-fall-through: rd_data shows the head entry while
// empty is low, and reads as zero while the FIFO is empty.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   push, push_data   - write request; accepted when not full or when a pop
//                       happens in the same cycle
//   pop               - read request; ignored while empty
//   rd_data           - head entry
//   full, empty       - occupancy flags
module result_fifo
    import miner_pkg::*;
#(
    parameter int WIDTH = RES_W,
    parameter int DEPTH = DEF_RES_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_s;
    logic             empty_s;
    logic             wr_en_s;
    logic             rd_en_s;

    assign full_s  = (count_r == (AW + 1)'(DEPTH));
    assign empty_s = (count_r == '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign rd_en_s = pop && !empty_s;
    assign wr_en_s = push && (!full_s || rd_en_s);
    assign full    = full_s;
    assign empty   = empty_s;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head entry, zeroed while empty so stale data never leaks out.
    always_comb begin
        rd_data = '0;
        if (empty_s) begin
            rd_data = '0;
        end else begin
            rd_data = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/nonce_scheduler.sv
// Nonce scheduler for a double-SHA mining datapath.
// Loads a job, walks dp_nonce from job_start to job_end as the datapath
// accepts nonces, ignores results during the datapath latency after a load
// (FLUSH), then captures hashes with ZERO_BITS leading zeros into a result
// FIFO. After the last nonce the datapath is drained for FLUSH_CYCLES more
// cycles before done pulses.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   job_valid, job_x/y/start/end     - job load (always accepted)
//   dp_x, dp_y, dp_nonce             - to datapath
//   dp_accepted                      - datapath took dp_nonce
//   dp_hash, dp_out_nonce            - datapath results, one per cycle
//   res_valid/ready/nonce/hash       - result stream
//   busy, done, drop_count           - status
module nonce_scheduler
    import miner_pkg::*;
#(
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int ZERO_BITS    = DEF_ZERO_BITS,
    parameter int RES_DEPTH    = DEF_RES_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    input  logic [255:0] job_x,
    input  logic [95:0]  job_y,
    input  logic [31:0]  job_start,
    input  logic [31:0]  job_end,
    output logic [255:0] dp_x,
    output logic [95:0]  dp_y,
    output logic [31:0]  dp_nonce,
    input  logic         dp_accepted,
    input  logic [255:0] dp_hash,
    input  logic [31:0]  dp_out_nonce,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [31:0]  res_nonce,
    output logic [255:0] res_hash,
    output logic         busy,
    output logic         done,
    output logic [7:0]   drop_count
);

    localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    sched_state_t       state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [255:0]       dp_x_r;
    logic [95:0]        dp_y_r;
    logic [31:0]        nonce_r;
    logic [31:0]        job_end_r;
    logic               busy_r;
    logic               done_r;
    logic [7:0]         drop_count_r;
    logic [31:0]        last_nonce_r;
    logic               last_valid_r;

    logic               qualify_s;
    logic               drop_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [RES_W-1:0]   fifo_rd_data_s;

    assign dp_x       = dp_x_r;
    assign dp_y       = dp_y_r;
    assign dp_nonce   = nonce_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign drop_count = drop_count_r;
    assign res_valid  = !fifo_empty_s;
    assign res_nonce  = fifo_rd_data_s[RES_W-1 -: 32];
    assign res_hash   = fifo_rd_data_s[255:0];

    // Main scheduler FSM: job load, nonce walk, flush and drain timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            dp_x_r    <= '0;
            dp_y_r    <= '0;
            nonce_r   <= 32'd0;
            job_end_r <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else if (job_valid) begin
            // A new job wins over anything the current job is doing.
            state_r   <= ST_FLUSH;
            cnt_r     <= CNT_W'(FLUSH_CYCLES);
            dp_x_r    <= job_x;
            dp_y_r    <= job_y;
            nonce_r   <= job_start;
            job_end_r <= job_end;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                end
                ST_FLUSH, ST_RUN: begin
                    if (dp_accepted && (nonce_r == job_end_r)) begin
                        // Last nonce issued: hold it and wait out the pipeline.
                        state_r <= ST_DRAIN;
                        cnt_r   <= CNT_W'(FLUSH_CYCLES);
                    end else begin
                        if (dp_accepted) begin
                            nonce_r <= nonce_r + 32'd1;
                        end
                        if (state_r == ST_FLUSH) begin
                            if (cnt_r <= CNT_W'(1)) begin
                                state_r <= ST_RUN;
                                cnt_r   <= '0;
                            end else begin
                                cnt_r <= cnt_r - CNT_W'(1);
                            end
                        end
                    end
                    busy_r <= 1'b1;
                end
                ST_DRAIN: begin
                    if (cnt_r <= CNT_W'(1)) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r  <= cnt_r - CNT_W'(1);
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Result qualification; the last-nonce compare suppresses repeats of a
    // held terminal nonce coming out of the datapath.
    always_comb begin
        qualify_s = 1'b0;
        drop_s    = 1'b0;
        if (((state_r == ST_RUN) || (state_r == ST_DRAIN)) &&
            hash_meets_target(dp_hash, ZERO_BITS) &&
            !(last_valid_r && (dp_out_nonce == last_nonce_r))) begin
            qualify_s = 1'b1;
        end else begin
            qualify_s = 1'b0;
        end
        // A pop in the same cycle frees the slot, so only then is it not a drop.
        if (qualify_s && fifo_full_s && !res_ready) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    // Last qualified nonce tracking and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_nonce_r <= 32'd0;
            last_valid_r <= 1'b0;
            drop_count_r <= 8'd0;
        end else begin
            if (qualify_s) begin
                last_nonce_r <= dp_out_nonce;
                last_valid_r <= 1'b1;
            end
            if (drop_s) begin
                drop_count_r <= sat_inc8(drop_count_r);
            end
        end
    end

    result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (qualify_s),
        .push_data ({dp_out_nonce, dp_hash}),
        .pop       (res_ready),
        .rd_data   (fifo_rd_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed self-checking bench for nonce_scheduler (FLUSH_CYCLES = 4).
module tb_nonce_scheduler;

    logic         clk;
    logic         rst;
    logic         job_valid;
    logic [255:0] job_x;
    logic [95:0]  job_y;
    logic [31:0]  job_start;
    logic [31:0]  job_end;
    logic [255:0] dp_x;
    logic [95:0]  dp_y;
    logic [31:0]  dp_nonce;
    logic         dp_accepted;
    logic [255:0] dp_hash;
    logic [31:0]  dp_out_nonce;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res_nonce;
    logic [255:0] res_hash;
    logic         busy;
    logic         done;
    logic [7:0]   drop_count;

    int checks_cnt = 0;
    int errors_cnt = 0;

    localparam logic [255:0] BAD_HASH = {256{1'b1}};
    localparam logic [255:0] GOOD_HASH = {32'h0, 32'hDEADBEEF, 192'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_1122_3344_5566_7788};

    nonce_scheduler #(
        .FLUSH_CYCLES (4),
        .ZERO_BITS    (32),
        .RES_DEPTH    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .job_valid    (job_valid),
        .job_x        (job_x),
        .job_y        (job_y),
        .job_start    (job_start),
        .job_end      (job_end),
        .dp_x         (dp_x),
        .dp_y         (dp_y),
        .dp_nonce     (dp_nonce),
        .dp_accepted  (dp_accepted),
        .dp_hash      (dp_hash),
        .dp_out_nonce (dp_out_nonce),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_nonce    (res_nonce),
        .res_hash     (res_hash),
        .busy         (busy),
        .done         (done),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_job(input logic [31:0] s, input logic [31:0] e, input logic [255:0] x);
        job_valid = 1'b1;
        job_start = s;
        job_end   = e;
        job_x     = x;
        job_y     = {32'hAAAA0001, 32'hBBBB0002, s};
        tick();
        job_valid = 1'b0;
    endtask

    initial begin
        logic seen;
        rst          = 1'b1;
        job_valid    = 1'b0;
        job_x        = '0;
        job_y        = '0;
        job_start    = 32'd0;
        job_end      = 32'd0;
        dp_accepted  = 1'b0;
        dp_hash      = BAD_HASH;
        dp_out_nonce = 32'd0;
        res_ready    = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_nonce", dp_nonce, 288'h0);
        check("rst_busy", busy, 288'h0);
        check("rst_done", done, 288'h0);
        check("rst_res_valid", res_valid, 288'h0);
        check("rst_drop", drop_count, 288'h0);
        check("rst_dp_x", dp_x, 288'h0);

        // Basic walk 0x10..0x13 with constant accept, then drain and done.
        dp_accepted = 1'b1;
        load_job(32'h10, 32'h13, 256'h1111);
        check("t1_dp_x", dp_x, 288'h1111);
        check("t1_dp_y", dp_y, {192'h0, 32'hAAAA0001, 32'hBBBB0002, 32'h10});
        check("t1_n10", dp_nonce, 288'h10);
        check("t1_busy", busy, 288'h1);
        tick(); check("t1_n11", dp_nonce, 288'h11);
        tick(); check("t1_n12", dp_nonce, 288'h12);
        tick(); check("t1_n13", dp_nonce, 288'h13);
        tick(); // terminal accept
        check("t1_hold13", dp_nonce, 288'h13);
        check("t1_drain_busy", busy, 288'h1);
        check("t1_done_e0", done, 288'h0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("t1_done_early", done, 288'h0);
        end
        tick();
        check("t1_done_pulse", done, 288'h1);
        check("t1_busy_fall", busy, 288'h0);
        tick();
        check("t1_done_one", done, 288'h0);

        // Qualifying hash during FLUSH is ignored, then captured once in RUN.
        dp_accepted  = 1'b0;
        dp_hash      = GOOD_HASH;
        dp_out_nonce = 32'hB2957C05;
        load_job(32'h100, 32'h1FF, 256'h2222);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_flush_nopush", res_valid, 288'h0);
        end
        tick();
        check("t2_run_valid", res_valid, 288'h1);
        check("t2_run_nonce", res_nonce, 288'hB2957C05);
        check("t2_run_hash", res_hash, {32'h0, GOOD_HASH});
        tick();
        tick(); // same nonce held for three cycles total
        dp_hash   = BAD_HASH;
        res_ready = 1'b1;
        tick();
        check("t3_dedupe_one", res_valid, 288'h0);
        check("t2_hold_nonce", dp_nonce, 288'h100);

        // Six distinct results with no reader: four kept, two dropped.
        res_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            dp_out_nonce = 32'h1000 + 32'(i);
            dp_hash      = {32'h0, 192'h0, 32'hA0000000 + 32'(i)};
            tick();
        end
        dp_hash = BAD_HASH;
        check("t4_drop2", drop_count, 288'h2);
        check("t4_valid", res_valid, 288'h1);
        res_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("t4_pop_nonce", res_nonce, 288'(32'h1000 + 32'(i)));
            check("t4_pop_hash", res_hash, 288'(32'hA0000000 + 32'(i)));
            tick();
        end
        check("t4_empty", res_valid, 288'h0);
        check("t4_drop_stay", drop_count, 288'h2);
        res_ready = 1'b0;

        // Nonce wrap across 2^32.
        dp_accepted = 1'b1;
        load_job(32'hFFFFFFFE, 32'h00000001, 256'h3333);
        check("t5_fffffffe", dp_nonce, 288'hFFFFFFFE);
        tick(); check("t5_ffffffff", dp_nonce, 288'hFFFFFFFF);
        tick(); check("t5_0", dp_nonce, 288'h0);
        tick(); check("t5_1", dp_nonce, 288'h1);
        tick(); check("t5_hold1", dp_nonce, 288'h1);
        check("t5_drain_busy", busy, 288'h1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("t5_done_seen", seen, 288'h1);

        // Single-nonce job: one nonce, then drain of four cycles.
        load_job(32'h55, 32'h55, 256'h4444);
        check("t6_n55", dp_nonce, 288'h55);
        tick();
        check("t6_hold55", dp_nonce, 288'h55);
        tick(); tick(); tick();
        check("t6_done_early", done, 288'h0);
        tick();
        check("t6_done", done, 288'h1);

        // New job coincident with a terminal accept takes priority.
        load_job(32'h70, 32'h70, 256'h5555);
        job_valid = 1'b1;
        job_start = 32'h80;
        job_end   = 32'h81;
        job_x     = 256'h6666;
        tick();
        job_valid = 1'b0;
        check("t7_prio_nonce", dp_nonce, 288'h80);
        check("t7_prio_x", dp_x, 288'h6666);
        tick();
        check("t7_n81", dp_nonce, 288'h81);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("t7_done_seen", seen, 288'h1);

        // Reset mid-RUN with two stored results, with a coincident job_valid.
        dp_accepted = 1'b0;
        load_job(32'h200, 32'h2FF, 256'h7777);
        for (int i = 0; i < 4; i++) tick();
        for (int i = 1; i <= 2; i++) begin
            dp_out_nonce = 32'h3000 + 32'(i);
            dp_hash      = GOOD_HASH;
            tick();
        end
        dp_hash = BAD_HASH;
        check("t8_two_valid", res_valid, 288'h1);
        rst       = 1'b1;
        job_valid = 1'b1;
        job_start = 32'h999;
        tick();
        rst       = 1'b0;
        job_valid = 1'b0;
        check("t8_rst_valid", res_valid, 288'h0);
        check("t8_rst_busy", busy, 288'h0);
        check("t8_rst_nonce", dp_nonce, 288'h0);
        check("t8_rst_x", dp_x, 288'h0);
        check("t8_rst_drop", drop_count, 288'h0);
        check("t8_rst_resn", res_nonce, 288'h0);
        check("t8_rst_done", done, 288'h0);
        load_job(32'h400, 32'h4FF, 256'h8888);
        check("t8_restart", dp_nonce, 288'h400);
        check("t8_restart_busy", busy, 288'h1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/nonce_scheduler.md
NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 64: cycles of datapath latency during which results are treated as stale after a job load.
REQ-002 SHALL have parameter ZERO_BITS, default 32: number of leading zero hash bits required for a result.
REQ-003 SHALL have parameter RES_DEPTH, default 4 (power of 2): result FIFO depth.
REQ-004 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port job_valid, input, 1: one-cycle pulse, load new job (always accepted).
REQ-007 SHALL have ports job_x (input, 256), job_y (input, 96), job_start (input, 32) and job_end (input, 32): midstate, tail words, first nonce, last nonce.
REQ-008 SHALL have ports dp_x (output, 256), dp_y (output, 96) and dp_nonce (output, 32): drive the double-SHA datapath.
REQ-009 SHALL have port dp_accepted, input, 1: datapath consumed dp_nonce this cycle.
REQ-010 SHALL have ports dp_hash (input, 256) and dp_out_nonce (input, 32): datapath output, new value every cycle.
REQ-011 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_nonce (output, 32) and res_hash (output, 256): valid/ready result stream to the UART transmitter.
REQ-012 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and drop_count (output, 8, saturating).

Function
REQ-013 SHALL implement FSM states IDLE, FLUSH, RUN, DRAIN.
REQ-014 job_valid in any state SHALL register job_x/job_y into dp_x/dp_y, set dp_nonce=job_start, load flush counter with FLUSH_CYCLES, go to FLUSH, and discard no FIFO entries.
REQ-015 In FLUSH and RUN, dp_accepted SHALL advance dp_nonce by 1 (mod 2^32) next cycle, unless dp_nonce==job_end.
REQ-016 dp_accepted with dp_nonce==job_end in FLUSH or RUN SHALL hold dp_nonce, reload the flush counter, and go to DRAIN.
REQ-017 FLUSH SHALL decrement its counter each cycle, move to RUN when it reaches 0, and suppress all result checking.
REQ-018 DRAIN SHALL check results, decrement the counter, and at 0 go to IDLE with done=1 for exactly that cycle.
REQ-019 A result SHALL qualify in RUN or DRAIN when dp_hash[255:256-ZERO_BITS]==0 and dp_out_nonce differs from the last qualified nonce (dedupes held nonce).
REQ-020 Each qualifying result SHALL be pushed {dp_out_nonce, dp_hash} the same cycle; the push is visible on res_* next cycle if the FIFO was empty.
REQ-021 A qualifying result arriving while the FIFO is full SHALL be dropped and drop_count incremented, saturating at 255.
REQ-022 The FIFO SHALL pop when res_valid && res_ready; simultaneous push and pop when full SHALL accept the push.
REQ-023 res_valid=1 iff FIFO non-empty; res_nonce/res_hash SHALL be stable while res_valid && !res_ready.
REQ-024 busy SHALL be 1 in FLUSH, RUN and DRAIN.
REQ-025 job_valid coinciding with a terminal-nonce accept SHALL take priority (go to FLUSH).
REQ-026 job_start==job_end SHALL issue one nonce, then DRAIN.

Reset
REQ-027 rst SHALL force IDLE, dp_x=0, dp_y=0, dp_nonce=0, FIFO empty, res_valid=0, busy=0, done=0, drop_count=0, and clear the last-qualified-nonce valid flag, taking effect the cycle after assertion, including mid-job.
REQ-028 rst SHALL override a coincident job_valid.

Structure
REQ-029 State encoding and the default parameter constants SHALL live in a shared package (miner_pkg).
REQ-030 The result FIFO SHALL be a separate sub-module, result_fifo (parameterised width and depth), instantiated with width 288.

Verification
REQ-031 Job start=0x10, end=0x13, dp_accepted constant 1, FLUSH_CYCLES=4 -> dp_nonce sequence 0x10..0x13, DRAIN, done pulse 4 cycles after terminal accept, busy falls.
REQ-032 Qualifying hash (top 32 bits 0) injected during FLUSH -> no push; same injected in RUN with nonce 0xB2957C05 -> res_valid, res_nonce=0xB2957C05, exact hash.
REQ-033 Same qualifying nonce presented 3 consecutive cycles -> exactly one FIFO entry.
REQ-034 res_ready=0, 6 distinct qualifying results -> 4 stored in order, drop_count=2; then res_ready=1 -> 4 pops in order, res_valid falls.
REQ-035 job_start=0xFFFFFFFE, job_end=0x00000001 -> wraps 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1, then DRAIN.
REQ-036 rst mid-RUN with 2 FIFO entries -> next cycle all outputs at reset values; new job_valid after rst restarts at its job_start.
